// File: rtl/i2c_target_if.sv
// Processor-side register access bus for i2c_target: Read/Write strobes,
// register index and data, plus the target's status pulses.
interface i2c_target_if #(
    parameter int AW = 4
);
    logic          Read;
    logic          Write;
    logic [AW-1:0] Address;
    logic [7:0]    DataIn;
    logic [7:0]    DataOut;
    logic          Ack;
    logic          Busy;
    logic          RegWritten;

    modport master (
        output Read, Write, Address, DataIn,
        input  DataOut, Ack, Busy, RegWritten
    );

    modport slave (
        input  Read, Write, Address, DataIn,
        output DataOut, Ack, Busy, RegWritten
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target with a shared register file, reachable from I2C and the processor bus.
// Optional I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | not addressed, SDA released
// ADDR      | shifting in address byte after START
// ADDR_ACK  | driving ACK for matched address (9th clock)
// PTR       | shifting in register pointer byte
// PTR_ACK   | driving ACK for pointer byte
// WDATA     | shifting in write data, committed on 8th SCL rise
// WDATA_ACK | driving ACK for write data
// RDATA     | driving read data bits onto SDA
// RDATA_ACK | released SDA, sampling master ACK/NACK
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h42,
    parameter int         REGS = 16
) (
    input  logic        clock,
    input  logic        reset,
    i2c_target_if.slave bus,
    inout  wire         i2c_scl,
    inout  wire         i2c_sda
);
    localparam int AW = $clog2(REGS);

    typedef enum logic [3:0] {
        IDLE, ADDR_S, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
    } state_t;

    state_t        state;
    logic [7:0]    regs [0:REGS-1];
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [AW-1:0] ptr;
    logic          ack_half;
    logic          rd_mode;
    logic          sda_drive_low;

    logic scl_s1, scl_s2, sda_s1, sda_s2;
    logic scl_f, sda_f, scl_q, sda_q;

    assign i2c_sda = sda_drive_low ? 1'b0 : 1'bz;

    // Lines reset to 1 so an idle bus produces no spurious edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_s1 <= i2c_scl;
            scl_s2 <= scl_s1;
            sda_s1 <= i2c_sda;
            sda_s2 <= sda_s1;
            scl_q  <= scl_f;
            sda_q  <= sda_f;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_h, sda_h;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scl_h <= 2'b11;
            sda_h <= 2'b11;
            scl_f <= 1'b1;
            sda_f <= 1'b1;
        end else begin
            scl_h <= {scl_h[0], scl_s2};
            sda_h <= {sda_h[0], sda_s2};
            scl_f <= (scl_h[1] & scl_h[0]) | (scl_h[1] & scl_s2) | (scl_h[0] & scl_s2);
            sda_f <= (sda_h[1] & sda_h[0]) | (sda_h[1] & sda_s2) | (sda_h[0] & sda_s2);
        end
    end
`else
    assign scl_f = scl_s2;
    assign sda_f = sda_s2;
`endif

    logic          scl_rise, scl_fall, start_det, stop_det, last_bit, commit, collide;
    logic [7:0]    rx_byte;
    logic [AW-1:0] ptr_nxt;

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign rx_byte   = {shift[6:0], sda_f};
    assign last_bit  = (bit_cnt == 3'd7);
    assign commit    = (state == WDATA) & scl_rise & last_bit;
    assign collide   = commit & bus.Write & (ptr == bus.Address);
    assign ptr_nxt   = ptr + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            shift          <= '0;
            bit_cnt        <= '0;
            ptr            <= '0;
            ack_half       <= 1'b0;
            rd_mode        <= 1'b0;
            sda_drive_low  <= 1'b0;
            bus.Busy       <= 1'b0;
            bus.RegWritten <= 1'b0;
        end else begin
            bus.RegWritten <= commit;
            if (start_det) begin
                state         <= ADDR_S;
                bit_cnt       <= '0;
                ack_half      <= 1'b0;
                sda_drive_low <= 1'b0;
            end else if (stop_det) begin
                state         <= IDLE;
                bus.Busy      <= 1'b0;
                sda_drive_low <= 1'b0;
            end else begin
                case (state)
                    ADDR_S: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            if (rx_byte[7:1] == ADDR) begin
                                bus.Busy <= 1'b1;
                                state    <= ADDR_ACK;
                                ack_half <= 1'b0;
                                rd_mode  <= rx_byte[0];
                                if (rx_byte[0]) shift <= regs[ptr];
                            end else begin
                                bus.Busy <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (!ack_half) begin
                            sda_drive_low <= 1'b1;
                            ack_half      <= 1'b1;
                        end else begin
                            bit_cnt <= '0;
                            if (rd_mode) begin
                                state         <= RDATA;
                                sda_drive_low <= ~shift[7];
                            end else begin
                                state         <= PTR;
                                sda_drive_low <= 1'b0;
                            end
                        end
                    end
                    PTR, WDATA: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            ack_half <= 1'b0;
                            if (state == PTR) begin
                                ptr   <= rx_byte[AW-1:0];
                                state <= PTR_ACK;
                            end else begin
                                ptr   <= ptr_nxt;
                                state <= WDATA_ACK;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!ack_half) begin
                            sda_drive_low <= 1'b1;
                            ack_half      <= 1'b1;
                        end else begin
                            sda_drive_low <= 1'b0;
                            bit_cnt       <= '0;
                            state         <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                state    <= RDATA_ACK;
                                ack_half <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            sda_drive_low <= ~shift[3'd7 - bit_cnt];
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_half) begin
                                sda_drive_low <= 1'b0;
                                ack_half      <= 1'b1;
                            end else begin
                                state         <= RDATA;
                                bit_cnt       <= '0;
                                sda_drive_low <= ~shift[7];
                            end
                        end else if (scl_rise) begin
                            if (sda_f) begin
                                state    <= IDLE;
                                bus.Busy <= 1'b0;
                            end else begin
                                ptr   <= ptr_nxt;
                                shift <= regs[ptr_nxt];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // An I2C commit wins over a same-cycle bus write to the same register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REGS; i++) regs[i] <= '0;
            bus.DataOut <= '0;
            bus.Ack     <= 1'b0;
        end else begin
            bus.Ack <= bus.Read | bus.Write;
            if (bus.Write && !collide) regs[bus.Address] <= bus.DataIn;
            if (commit) regs[ptr] <= rx_byte;
            if (bus.Write) bus.DataOut <= collide ? rx_byte : bus.DataIn;
            else if (bus.Read) bus.DataOut <= regs[bus.Address];
        end
    end
endmodule
